wb_assoc_cache_ctrl: RTL and testbench

Parametrised write-back, write-allocate, set-associative data cache that sits between the core datapath and the byte-lane main memory, replacing the fixed direct-mapped cache datapath/controller pair. It merges tag/data arrays and the miss FSM, and adds configurable associativity with LRU, a multi-cycle memory handshake, byte-enable writes and a full dirty-flush mode. The core stalls on `stall`; memory sees one word-wide line per access.

---
 rtl/cache_pkg.sv | 25 ++
 rtl/wb_assoc_cache_ctrl_if.sv | 32 +++
 rtl/cache_way_array.sv | 58 +++++
 rtl/wb_assoc_cache_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_wb_assoc_cache_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the write-back set-associative cache.
//   cache_state_t : controller FSM states
//   IDX_BITS/TAG_BITS/LANES : geometry of the default build (XLEN=32, SETS=64)
//   merge_byte    : byte-lane merge under a lane enable
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    FLUSH_SCAN,
    FLUSH_WB
  } cache_state_t;

  localparam int unsigned IDX_BITS = 6;
  localparam int unsigned LANES    = 4;
  localparam int unsigned TAG_BITS = LANES * 8 - IDX_BITS - 2;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/wb_assoc_cache_ctrl_if.sv
// Core-side request bus and memory-side line bus of the cache.
//   master : core + main memory (drives requests, flush, mem_data_out)
//   slave  : the cache controller
interface wb_assoc_cache_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned NL = XLEN / 8;

  logic                 req_valid;
  logic                 req_we;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic [NL-1:0]        req_be;
  logic [XLEN-1:0]      rdata;
  logic                 stall;
  logic                 flush;
  logic                 flush_busy;
  logic [XLEN-1:0]      mem_addr;
  logic [NL-1:0][7:0]   mem_data_in;
  logic [NL-1:0][7:0]   mem_data_out;
  logic                 mem_write_en;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, flush, mem_data_out,
    input  rdata, stall, flush_busy, mem_addr, mem_data_in, mem_write_en
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, flush, mem_data_out,
    output rdata, stall, flush_busy, mem_addr, mem_data_in, mem_write_en
  );
endinterface

// File: rtl/cache_way_array.sv
// Storage for one cache way: per-set valid, dirty, tag and data word.
//   i_idx              : set addressed by both the read port and the write port
//   o_valid/o_dirty/o_tag/o_data : combinational read of set i_idx
//   i_data_we, i_be, i_wdata     : byte-enabled data write
//   i_fill, i_tag                : write tag and mark the line valid
//   i_dirty_we, i_dirty_val      : update the dirty bit
module cache_way_array
  import cache_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = TAG_BITS
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [$clog2(SETS)-1:0] i_idx,
  output logic                    o_valid,
  output logic                    o_dirty,
  output logic [TAG_W-1:0]        o_tag,
  output logic [XLEN-1:0]         o_data,
  input  logic                    i_data_we,
  input  logic [XLEN/8-1:0]       i_be,
  input  logic [XLEN-1:0]         i_wdata,
  input  logic                    i_fill,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic                    i_dirty_we,
  input  logic                    i_dirty_val
);
  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [XLEN-1:0]  r_data [SETS];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill)     r_valid[i_idx] <= 1'b1;
      if (i_dirty_we) r_dirty[i_idx] <= i_dirty_val;
    end
  end

  // Tag and data carry no reset: they are qualified by r_valid.
  always_ff @(posedge clk) begin
    if (i_fill) r_tag[i_idx] <= i_tag;
    if (i_data_we) begin
      for (int unsigned l = 0; l < XLEN / 8; l++) begin
        r_data[i_idx][l*8 +: 8] <= merge_byte(r_data[i_idx][l*8 +: 8], i_wdata[l*8 +: 8], i_be[l]);
      end
    end
  end
endmodule

// File: rtl/wb_assoc_cache_ctrl.sv
// Write-back, write-allocate, 1- or 2-way set-associative data cache with
// per-set LRU, a MEM_LATENCY-cycle memory handshake and a dirty-line flush.
//   clk, rst_b : clock, asynchronous active-low reset
//   bus        : slave side of the core request / memory line bus
module wb_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned XLEN        = LANES * 8,
  parameter int unsigned SETS        = 1 << IDX_BITS,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  wb_assoc_cache_ctrl_if.slave bus
);
  localparam int unsigned IB = $clog2(SETS);
  localparam int unsigned TB = XLEN - IB - 2;
  localparam int unsigned NL = XLEN / 8;
  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  cache_state_t     r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [XLEN-3:0]  r_miss_addr;
  logic             r_victim;
  logic [IB-1:0]    r_scan_set;
  logic             r_scan_way;

  logic [IB-1:0]    w_req_idx, w_miss_idx, w_idx;
  logic [TB-1:0]    w_req_tag;
  logic [WAYS-1:0]  w_valid, w_dirty, w_hit_vec;
  logic [TB-1:0]    w_tag  [WAYS];
  logic [XLEN-1:0]  w_data [WAYS];
  logic             w_hit, w_hit_way, w_victim, w_lru_way;
  logic             w_last_cnt, w_last_entry;
  logic [WAYS-1:0]  w_data_we, w_fill, w_dirty_we;
  logic [NL-1:0]    w_be;
  logic [XLEN-1:0]  w_wdata;
  logic             w_dirty_val;
  logic             w_unused;

  assign w_req_idx    = bus.req_addr[IB+1:2];
  assign w_req_tag    = bus.req_addr[XLEN-1:IB+2];
  assign w_miss_idx   = r_miss_addr[IB-1:0];
  assign w_last_cnt   = (r_cnt == CNT_LAST);
  assign w_last_entry = (r_scan_set == IB'(SETS - 1)) && (r_scan_way == 1'(WAYS - 1));
  assign w_unused     = &{1'b0, bus.req_addr[1:0]};

  // One shared index: the request in IDLE, the registered miss during a
  // miss, the scan pointer during a flush.
  always_comb begin
    w_idx = r_scan_set;
    if (r_state == IDLE) w_idx = w_req_idx;
    else if (r_state == WRITEBACK || r_state == REFILL) w_idx = w_miss_idx;
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_array #(.XLEN(XLEN), .SETS(SETS), .TAG_W(TB)) u_way (
      .clk         (clk),
      .rst_b       (rst_b),
      .i_idx       (w_idx),
      .o_valid     (w_valid[g]),
      .o_dirty     (w_dirty[g]),
      .o_tag       (w_tag[g]),
      .o_data      (w_data[g]),
      .i_data_we   (w_data_we[g]),
      .i_be        (w_be),
      .i_wdata     (w_wdata),
      .i_fill      (w_fill[g]),
      .i_tag       (r_miss_addr[XLEN-3:IB]),
      .i_dirty_we  (w_dirty_we[g]),
      .i_dirty_val (w_dirty_val)
    );
    assign w_hit_vec[g] = w_valid[g] && (w_tag[g] == w_req_tag);
  end

  assign w_hit = |w_hit_vec;

  always_comb begin
    w_hit_way = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (w_hit_vec[i]) w_hit_way = 1'(i);
    end
  end

  if (WAYS == 2) begin : g_lru
    // Bit = LRU way of the set; only hits touch it.
    logic [SETS-1:0] r_lru;
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) r_lru <= '0;
      else if (r_state == IDLE && !bus.flush && bus.req_valid && w_hit)
        r_lru[w_req_idx] <= ~w_hit_way;
    end
    assign w_lru_way = r_lru[w_req_idx];
  end else begin : g_no_lru
    assign w_lru_way = 1'b0;
  end

  // Invalid way first (way0 preferred), else LRU.
  always_comb begin
    w_victim = 1'b0;
    if (WAYS == 2 && w_valid[0]) w_victim = w_valid[WAYS-1] ? w_lru_way : 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.flush) w_next = FLUSH_SCAN;
        else if (bus.req_valid && !w_hit)
          w_next = (w_valid[w_victim] && w_dirty[w_victim]) ? WRITEBACK : REFILL;
      end
      WRITEBACK:  if (w_last_cnt) w_next = REFILL;
      REFILL:     if (w_last_cnt) w_next = IDLE;
      FLUSH_SCAN: begin
        if (w_dirty[r_scan_way]) w_next = FLUSH_WB;
        else if (w_last_entry)   w_next = IDLE;
      end
      FLUSH_WB:   if (w_last_cnt) w_next = w_last_entry ? IDLE : FLUSH_SCAN;
      default:    w_next = IDLE;
    endcase
  end

  // FSM: outputs and array write strobes
  always_comb begin
    bus.stall        = 1'b0;
    bus.flush_busy   = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data_in  = '0;
    bus.mem_write_en = 1'b0;
    bus.rdata        = '0;
    w_data_we        = '0;
    w_fill           = '0;
    w_dirty_we       = '0;
    w_be             = '0;
    w_wdata          = '0;
    w_dirty_val      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Gated by rst_b so a request held across reset does not stall.
        if (bus.flush) bus.stall = rst_b;
        else if (bus.req_valid) begin
          if (!w_hit) bus.stall = rst_b;
          else if (!bus.req_we) bus.rdata = w_data[w_hit_way];
          else begin
            w_data_we[w_hit_way]  = 1'b1;
            w_be                  = bus.req_be;
            w_wdata               = bus.req_wdata;
            w_dirty_we[w_hit_way] = 1'b1;
            w_dirty_val           = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        bus.stall        = 1'b1;
        bus.mem_addr     = {w_tag[r_victim], w_miss_idx, 2'b00};
        bus.mem_data_in  = w_data[r_victim];
        bus.mem_write_en = 1'b1;
        if (w_last_cnt) w_dirty_we[r_victim] = 1'b1;
      end
      REFILL: begin
        bus.stall    = 1'b1;
        bus.mem_addr = {r_miss_addr, 2'b00};
        if (w_last_cnt) begin
          w_data_we[r_victim]  = 1'b1;
          w_be                 = '1;
          w_wdata              = bus.mem_data_out;
          w_fill[r_victim]     = 1'b1;
          w_dirty_we[r_victim] = 1'b1;
        end
      end
      FLUSH_SCAN: begin
        bus.stall      = 1'b1;
        bus.flush_busy = 1'b1;
      end
      FLUSH_WB: begin
        bus.stall        = 1'b1;
        bus.flush_busy   = 1'b1;
        bus.mem_addr     = {w_tag[r_scan_way], r_scan_set, 2'b00};
        bus.mem_data_in  = w_data[r_scan_way];
        bus.mem_write_en = 1'b1;
        if (w_last_cnt) w_dirty_we[r_scan_way] = 1'b1;
      end
      default: ;
    endcase
  end

  // Hold counter: restarts on every state change, saturates at the last cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                 r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (!w_last_cnt)       r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_miss_addr <= '0;
      r_victim    <= 1'b0;
      r_scan_set  <= '0;
      r_scan_way  <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (bus.flush) begin
          r_scan_set <= '0;
          r_scan_way <= 1'b0;
        end else if (bus.req_valid && !w_hit) begin
          r_miss_addr <= bus.req_addr[XLEN-1:2];
          r_victim    <= w_victim;
        end
      end
      if ((r_state == FLUSH_SCAN && !w_dirty[r_scan_way]) ||
          (r_state == FLUSH_WB && w_last_cnt)) begin
        if (r_scan_way == 1'(WAYS - 1)) begin
          r_scan_way <= 1'b0;
          r_scan_set <= r_scan_set + 1'b1;
        end else begin
          r_scan_way <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_assoc_cache_ctrl.sv
module tb_wb_assoc_cache_ctrl;
  localparam int unsigned ML = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  wb_assoc_cache_ctrl_if #(.XLEN(32)) bus();

  wb_assoc_cache_ctrl #(.XLEN(32), .SETS(64), .WAYS(2), .MEM_LATENCY(ML)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // Main memory: combinational read; a write commits only after being held ML cycles.
  logic [31:0] mem [1024];
  assign bus.mem_data_out = mem[bus.mem_addr[11:2]];

  int errors = 0;
  int checks = 0;

  int          wr_cycles = 0;
  int          n_bursts = 0;
  int          run_len = 0;
  int          unstable = 0;
  logic        prev_we = 1'b0;
  logic [31:0] cur_addr, cur_data;
  logic [31:0] b_addr [16];
  logic [31:0] b_data [16];
  int          b_len  [16];

  always @(negedge clk) begin
    if (bus.mem_write_en) begin
      wr_cycles++;
      if (!prev_we) begin
        cur_addr = bus.mem_addr;
        cur_data = bus.mem_data_in;
        if (n_bursts < 16) begin
          b_addr[n_bursts] = cur_addr;
          b_data[n_bursts] = cur_data;
          b_len[n_bursts]  = 0;
        end
        n_bursts++;
        run_len = 0;
      end else if (bus.mem_addr != cur_addr || 32'(bus.mem_data_in) != cur_data) begin
        unstable++;
      end
      if (n_bursts <= 16) b_len[n_bursts-1]++;
      run_len++;
      if (run_len == ML) mem[cur_addr[11:2]] = cur_data;
    end else begin
      run_len = 0;
    end
    prev_we = bus.mem_write_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stalls;
    logic        chk_rd;
    logic [31:0] rd;
    int          wr_cyc;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input int stalls, input logic [31:0] rd,
                              input int wr_cyc, input logic [31:0] wr_addr, input logic [31:0] wr_data);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.stalls = stalls;
    v.chk_rd = !we; v.rd = rd; v.wr_cyc = wr_cyc; v.wr_addr = wr_addr; v.wr_data = wr_data;
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output int stalls, output logic [31:0] rd);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wd;   bus.req_be = be;
    stalls = 0;
    rd = '0;
    while (stalls <= 200) begin
      @(negedge clk);
      if (!bus.stall) break;
      stalls++;
    end
    rd = bus.rdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int          st;
    logic [31:0] rd;
    int          w0, nb0;
    for (int i = lo; i <= hi; i++) begin
      w0  = wr_cycles;
      nb0 = n_bursts;
      do_req(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].be, st, rd);
      check($sformatf("v%0d stall_cycles", i), st, tv[i].stalls);
      if (tv[i].chk_rd) check($sformatf("v%0d rdata", i), rd, tv[i].rd);
      check($sformatf("v%0d mem_write_cycles", i), wr_cycles - w0, tv[i].wr_cyc);
      if (tv[i].wr_cyc > 0 && nb0 < 16) begin
        check($sformatf("v%0d wb_addr", i), b_addr[nb0], tv[i].wr_addr);
        check($sformatf("v%0d wb_data", i), b_data[nb0], tv[i].wr_data);
      end
    end
  endtask

  task automatic do_flush(output int busy);
    @(posedge clk); #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    busy = 0;
    while (busy <= 1000) begin
      @(negedge clk);
      if (!bus.flush_busy) break;
      busy++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, nb0, busy, nwe, t;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h200 >> 2] = 32'h11112222;
    mem[32'h300 >> 2] = 32'h33334444;
    mem[32'h400 >> 2] = 32'h55556666;
    mem[32'h104 >> 2] = 32'hA0A0A0A0;
    mem[32'h008 >> 2] = 32'h0B0B0B0B;
    mem[32'h00C >> 2] = 32'h0C0C0C0C;
    mem[32'h10C >> 2] = 32'h1C1C1C1C;
    mem[32'h20C >> 2] = 32'h2C2C2C2C;

    //          we  addr          wdata         be      st rd            wr addr      data
    tv.push_back(mk(0, 32'h100, 32'h0,        4'h0, 5, 32'hDEADBEEF, 0, 0,       0));             // 0 cold
    tv.push_back(mk(0, 32'h100, 32'h0,        4'h0, 0, 32'hDEADBEEF, 0, 0,       0));             // 1 reload
    tv.push_back(mk(1, 32'h100, 32'h000000AA, 4'h1, 0, 32'h0,        0, 0,       0));             // 2 byte store
    tv.push_back(mk(0, 32'h100, 32'h0,        4'h0, 0, 32'hDEADBEAA, 0, 0,       0));             // 3
    tv.push_back(mk(0, 32'h200, 32'h0,        4'h0, 5, 32'h11112222, 0, 0,       0));             // 4 way1 fill
    tv.push_back(mk(0, 32'h200, 32'h0,        4'h0, 0, 32'h11112222, 0, 0,       0));             // 5
    tv.push_back(mk(0, 32'h300, 32'h0,        4'h0, 9, 32'h33334444, 4, 32'h100, 32'hDEADBEAA)); // 6 dirty evict
    tv.push_back(mk(0, 32'h200, 32'h0,        4'h0, 0, 32'h11112222, 0, 0,       0));             // 7
    tv.push_back(mk(0, 32'h400, 32'h0,        4'h0, 5, 32'h55556666, 0, 0,       0));             // 8 LRU victim
    tv.push_back(mk(0, 32'h200, 32'h0,        4'h0, 0, 32'h11112222, 0, 0,       0));             // 9
    tv.push_back(mk(1, 32'h200, 32'h0000BB00, 4'h2, 0, 32'h0,        0, 0,       0));             // 10
    tv.push_back(mk(1, 32'h104, 32'h01234567, 4'hF, 5, 32'h0,        0, 0,       0));             // 11 store miss
    tv.push_back(mk(1, 32'h008, 32'hCC000000, 4'h8, 5, 32'h0,        0, 0,       0));             // 12
    tv.push_back(mk(0, 32'h200, 32'h0,        4'h0, 0, 32'h1111BB22, 0, 0,       0));             // 13 after flush
    tv.push_back(mk(0, 32'h104, 32'h0,        4'h0, 0, 32'h01234567, 0, 0,       0));             // 14
    tv.push_back(mk(0, 32'h008, 32'h0,        4'h0, 0, 32'hCC0B0B0B, 0, 0,       0));             // 15
    tv.push_back(mk(0, 32'h400, 32'h0,        4'h0, 0, 32'h55556666, 0, 0,       0));             // 16
    tv.push_back(mk(1, 32'h00C, 32'hC0C0C0C0, 4'hF, 5, 32'h0,        0, 0,       0));             // 17
    tv.push_back(mk(1, 32'h10C, 32'hD1D1D1D1, 4'hF, 5, 32'h0,        0, 0,       0));             // 18
    tv.push_back(mk(0, 32'h00C, 32'h0,        4'h0, 5, 32'h0C0C0C0C, 0, 0,       0));             // 19 after reset
    tv.push_back(mk(0, 32'h10C, 32'h0,        4'h0, 5, 32'h1C1C1C1C, 0, 0,       0));             // 20
    tv.push_back(mk(0, 32'h200, 32'h0,        4'h0, 5, 32'h1111BB22, 0, 0,       0));             // 21
    tv.push_back(mk(0, 32'h400, 32'h0,        4'h0, 5, 32'h55556666, 0, 0,       0));             // 22

    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h100;
    bus.req_wdata = '0;   bus.req_be = '0;   bus.flush = 1'b0;
    #2;
    check("reset stall", bus.stall, 0);
    check("reset flush_busy", bus.flush_busy, 0);
    check("reset mem_write_en", bus.mem_write_en, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset rdata", bus.rdata, 0);
    check("reset mem_data_in", bus.mem_data_in, 0);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    run_vecs(0, 12);

    // Flush of three dirty lines: (0,1)=0x200, (1,0)=0x104, (2,0)=0x008.
    w0 = wr_cycles; nb0 = n_bursts;
    do_flush(busy);
    check("flush busy_cycles", busy, 128 + 3 * ML);
    check("flush write_cycles", wr_cycles - w0, 3 * ML);
    check("flush bursts", n_bursts - nb0, 3);
    check("flush b0 addr", b_addr[nb0],   32'h200);
    check("flush b0 data", b_data[nb0],   32'h1111BB22);
    check("flush b0 len",  b_len[nb0],    ML);
    check("flush b1 addr", b_addr[nb0+1], 32'h104);
    check("flush b1 data", b_data[nb0+1], 32'h01234567);
    check("flush b1 len",  b_len[nb0+1],  ML);
    check("flush b2 addr", b_addr[nb0+2], 32'h008);
    check("flush b2 data", b_data[nb0+2], 32'hCC0B0B0B);
    check("flush b2 len",  b_len[nb0+2],  ML);
    check("flush mem 0x200", mem[32'h200 >> 2], 32'h1111BB22);

    run_vecs(13, 16);

    // All dirty bits cleared: a second flush writes nothing.
    w0 = wr_cycles;
    do_flush(busy);
    check("flush2 busy_cycles", busy, 128);
    check("flush2 write_cycles", wr_cycles - w0, 0);

    run_vecs(17, 18);

    // Reset in the 2nd WRITEBACK cycle of a dirty miss on 0x20C (victim 0x00C).
    nb0 = n_bursts;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h20C;
    nwe = 0; t = 0;
    while (nwe < 2 && t < 50) begin
      @(negedge clk);
      t++;
      if (bus.mem_write_en) nwe++;
    end
    check("rstwb reached_2nd_wb_cycle", nwe, 2);
    check("rstwb burst addr", b_addr[nb0], 32'h00C);
    rst_b = 1'b0;
    #1;
    check("rstwb mem_write_en", bus.mem_write_en, 0);
    check("rstwb stall", bus.stall, 0);
    check("rstwb mem_addr", bus.mem_addr, 0);
    w0 = wr_cycles;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstwb writes_during_reset", wr_cycles - w0, 0);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    check("rstwb writes_after_release", wr_cycles - w0, 0);
    check("rstwb mem 0x00C kept", mem[32'h00C >> 2], 32'h0C0C0C0C);

    run_vecs(19, 22);

    check("write_hold_stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
